// File: rtl/led_seq_pkg.sv
// LED sequencer shared types: modes, config register offsets, FSM states.
// Imported by led_seq_step_timer and led_pio_sequencer.
package led_seq_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PATTERN = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_CHASE_L = 2'd2,
    MODE_CHASE_R = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

endpackage

// File: rtl/led_seq_step_timer.sv
// Step-period counter: clear, run, boundary pulse; PERIOD 0 acts as 1.
// Ports: clk, reset, clear, run, fire_en, period -> boundary.
module led_seq_step_timer
  import led_seq_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                run,
  input  logic                fire_en,
  input  logic [PERIOD_W-1:0] period,
  output logic                boundary
);

  logic [PERIOD_W-1:0] count_q, count_d;
  logic [PERIOD_W-1:0] last;
  logic                term;

  // While fire_en is low (strobe cycle) a terminal count is held,
  // so the step lands on the first counting cycle after it.
  always_comb begin
    last = (period == '0) ? '0 : period - PERIOD_W'(1);
    term = (count_q == last);
    boundary = run & fire_en & term;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      if (!term) begin
        count_d = count_q + PERIOD_W'(1);
      end else if (fire_en) begin
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_pio_sequencer.sv
// LED pattern engine driving PIO s1 writes; config via Avalon-MM slave.
// Ports: s_* config slave, m_* PIO master, irq (LED_SEQ_IRQ_EN only).
module led_pio_sequencer
  import led_seq_pkg::*;
#(
  parameter int                 LED_W      = 8,
  parameter int                 PERIOD_W   = 24,
  parameter logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(5000000)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        irq
);

  logic                enable_q, enable_d;
  mode_e               mode_q, mode_d;
  logic [LED_W-1:0]    pattern_q, pattern_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  state_e              state_q, state_d;
  logic [LED_W-1:0]    cur_q, cur_d;
  logic [LED_W-1:0]    wdata_q, wdata_d;
  logic [7:0]          step_q, step_d;
  logic                pending_q, pending_d;
  logic                blink_on_q, blink_on_d;
  logic                cs_q, cs_d;

  logic wr, wr_ctrl, wr_pat, wr_per;
  logic start, pend_set;
  logic tmr_run, tmr_fire, boundary;
  logic chase_step, blink_ret;
  logic [LED_W-1:0] rol, ror;

  assign wr      = s_chipselect & ~s_write_n;
  assign wr_ctrl = wr & (s_address == REG_CTRL);
  assign wr_pat  = wr & (s_address == REG_PATTERN);
  assign wr_per  = wr & (s_address == REG_PERIOD);
  assign start   = wr_ctrl & s_writedata[0] & ~enable_q;
  // A disabling CTRL write must not trigger a refresh write.
  assign pend_set = wr_pat
                  | (wr_ctrl & ~start & (s_writedata[0] | ~enable_q));

  assign tmr_run  = enable_q & (state_q != ST_IDLE);
  assign tmr_fire = (state_q == ST_COUNT);

  assign rol = {cur_q[LED_W-2:0], cur_q[LED_W-1]};
  assign ror = {cur_q[0], cur_q[LED_W-1:1]};

  led_seq_step_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (start),
    .run     (tmr_run),
    .fire_en (tmr_fire),
    .period  (period_q),
    .boundary(boundary)
  );

  always_comb begin
    enable_d   = enable_q;
    mode_d     = mode_q;
    pattern_d  = pattern_q;
    period_d   = period_q;
    state_d    = state_q;
    cur_d      = cur_q;
    wdata_d    = wdata_q;
    step_d     = step_q;
    blink_on_d = blink_on_q;
    cs_d       = 1'b0;
    chase_step = 1'b0;
    blink_ret  = 1'b0;
    pending_d  = pending_q | pend_set;

    if (wr_ctrl) begin
      enable_d = s_writedata[0];
      mode_d   = mode_e'(s_writedata[2:1]);
    end
    if (wr_pat) pattern_d = s_writedata[LED_W-1:0];
    if (wr_per) period_d = s_writedata[PERIOD_W-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d    = ST_ISSUE;
          cur_d      = pattern_q;
          blink_on_d = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else if (boundary) begin
          state_d = ST_ISSUE;
          unique case (mode_q)
            MODE_STATIC: begin
              cur_d      = pattern_q;
              blink_on_d = 1'b1;
            end
            MODE_BLINK: begin
              cur_d      = blink_on_q ? '0 : pattern_q;
              blink_on_d = ~blink_on_q;
              blink_ret  = ~blink_on_q;
            end
            MODE_CHASE_L: begin
              cur_d      = rol;
              chase_step = 1'b1;
            end
            MODE_CHASE_R: begin
              cur_d      = ror;
              chase_step = 1'b1;
            end
          endcase
        end else if (pending_q && mode_q == MODE_STATIC) begin
          state_d    = ST_ISSUE;
          cur_d      = pattern_q;
          blink_on_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        cs_d    = 1'b1;
        wdata_d = cur_q;
        step_d  = step_q + 8'd1;
        state_d = enable_q ? ST_COUNT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d    = ST_ISSUE;
      cur_d      = pattern_q;
      blink_on_d = 1'b1;
      step_d     = 8'd0;
    end

    // A write landing on the same edge keeps pending for a later refresh.
    if (state_d == ST_ISSUE && state_q != ST_ISSUE && !pend_set)
      pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q   <= 1'b0;
      mode_q     <= MODE_STATIC;
      pattern_q  <= '0;
      period_q   <= PERIOD_RST;
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      wdata_q    <= '0;
      step_q     <= 8'd0;
      pending_q  <= 1'b0;
      blink_on_q <= 1'b0;
      cs_q       <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      pattern_q  <= pattern_d;
      period_q   <= period_d;
      state_q    <= state_d;
      cur_q      <= cur_d;
      wdata_q    <= wdata_d;
      step_q     <= step_d;
      pending_q  <= pending_d;
      blink_on_q <= blink_on_d;
      cs_q       <= cs_d;
    end
  end

`ifdef LED_SEQ_IRQ_EN
  localparam int ROT_W = $clog2(LED_W);
  logic [ROT_W-1:0] rot_q, rot_d;
  logic             irq_q, irq_d;

  // Set is applied after clear so a same-cycle set wins.
  always_comb begin
    rot_d = rot_q;
    irq_d = irq_q;
    if (wr_ctrl && s_writedata[3]) irq_d = 1'b0;
    if (start) begin
      rot_d = '0;
    end else if (chase_step) begin
      if (rot_q == ROT_W'(LED_W - 1)) begin
        rot_d = '0;
        irq_d = 1'b1;
      end else begin
        rot_d = rot_q + ROT_W'(1);
      end
    end
    if (blink_ret) irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rot_q <= '0;
      irq_q <= 1'b0;
    end else begin
      rot_q <= rot_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{s_writedata, chase_step, blink_ret};

  always_comb begin
    s_readdata = '0;
    unique case (s_address)
      REG_CTRL:    s_readdata = {29'd0, mode_q, enable_q};
      REG_PATTERN: s_readdata = 32'(pattern_q);
      REG_PERIOD:  s_readdata = 32'(period_q);
      REG_STATUS:  s_readdata = {16'd0, step_q, 7'd0, pending_q};
      default:     s_readdata = '0;
    endcase
  end

  assign m_address    = 2'd0;
  assign m_chipselect = cs_q;
  assign m_write_n    = ~cs_q;
  assign m_writedata  = 32'(wdata_q);

endmodule
